// File: rtl/dct_pkg.sv
// Shared definitions for the DCT pipeline stages: approximation modes and
// the low-bit truncation helper used wherever a stage supports approx mode.
package dct_pkg;

  typedef enum logic [1:0] {
    AX_EXACT = 2'b00,
    AX_LO    = 2'b01,
    AX_HI    = 2'b10,
    AX_HI2   = 2'b11
  } approx_mode_t;

  localparam int DCT_MAX_W = 32;

  // Clearing LSBs of a two's-complement value rounds toward minus infinity;
  // callers zero-extend into DCT_MAX_W and keep their own low W bits.
  function automatic logic [DCT_MAX_W-1:0] dct_approx(
    input logic [DCT_MAX_W-1:0] value,
    input approx_mode_t         mode,
    input int                   lo_bits,
    input int                   hi_bits
  );
    logic [DCT_MAX_W-1:0] mask;
    case (mode)
      AX_EXACT: mask = '1;
      AX_LO:    mask = ~((DCT_MAX_W'(1) << lo_bits) - DCT_MAX_W'(1));
      default:  mask = ~((DCT_MAX_W'(1) << hi_bits) - DCT_MAX_W'(1));
    endcase
    return value & mask;
  endfunction

endpackage

// File: rtl/dct_transpose_pingpong_if.sv
// Row-in / column-out handshake bundle of the ping-pong transpose stage.
interface dct_transpose_pingpong_if #(
  parameter int N = 8,
  parameter int W = 12
);
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0][W-1:0] in_row;
  logic [1:0]          in_approx;
  logic                out_valid;
  logic                out_ready;
  logic [N-1:0][W-1:0] out_col;
  logic                out_last;
  logic                blk_done;

  modport master (
    output in_valid, in_row, in_approx, out_ready,
    input  in_ready, out_valid, out_col, out_last, blk_done
  );

  modport slave (
    input  in_valid, in_row, in_approx, out_ready,
    output in_ready, out_valid, out_col, out_last, blk_done
  );
endinterface

// File: rtl/dct_tp_bank.sv
// One NxN sample bank: row-wide write port, column read mux with
// per-block approximation applied on the way out.
module dct_tp_bank
  import dct_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = 12,
  parameter int APPROX_LO = 2,
  parameter int APPROX_HI = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [$clog2(N)-1:0]   wr_row,
  input  logic [N-1:0][W-1:0]    wr_data,
  input  logic                   mode_en,
  input  approx_mode_t           mode_in,
  input  logic [$clog2(N)-1:0]   rd_col,
  output logic [N-1:0][W-1:0]    rd_data
);

  logic [N-1:0][N-1:0][W-1:0] mem;
  approx_mode_t               mode;
  logic [DCT_MAX_W-1:0]       approx_val;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mode <= AX_EXACT;
    else if (mode_en) mode <= mode_in;
  end

  always_comb begin
    rd_data    = '0;
    approx_val = '0;
    for (int r = 0; r < N; r++) begin
      approx_val = dct_approx(DCT_MAX_W'(mem[r][rd_col]), mode, APPROX_LO, APPROX_HI);
      rd_data[r] = approx_val[W-1:0];
    end
  end

endmodule

// File: rtl/dct_transpose_pingpong.sv
// Double-buffered transpose: rows are written into one bank while the
// other bank is read out column by column.
module dct_transpose_pingpong
  import dct_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = 12,
  parameter int APPROX_LO = 2,
  parameter int APPROX_HI = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  dct_transpose_pingpong_if.slave   bus
);

  localparam int            RW   = $clog2(N);
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  logic [1:0]    full, full_next;
  logic          wr_bank, wr_bank_next;
  logic          rd_bank, rd_bank_next;
  logic [RW-1:0] wr_row, wr_row_next;
  logic [RW-1:0] rd_col, rd_col_next;
  logic          blk_done_q, blk_done_next;

  logic          in_ready, out_valid, out_last, wr_fire, rd_fire;
  logic [1:0]    wr_en, mode_en;
  logic [1:0][N-1:0][W-1:0] bank_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full       <= 2'b00;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_row     <= '0;
      rd_col     <= '0;
      blk_done_q <= 1'b0;
    end else begin
      full       <= full_next;
      wr_bank    <= wr_bank_next;
      rd_bank    <= rd_bank_next;
      wr_row     <= wr_row_next;
      rd_col     <= rd_col_next;
      blk_done_q <= blk_done_next;
    end
  end

  // Write and read sides only ever touch different banks, so a bank being
  // filled and the other being released in one cycle both take effect.
  always_comb begin
    full_next     = full;
    wr_bank_next  = wr_bank;
    rd_bank_next  = rd_bank;
    wr_row_next   = wr_row;
    rd_col_next   = rd_col;
    blk_done_next = 1'b0;
    if (wr_fire) begin
      if (wr_row == LAST) begin
        full_next[wr_bank] = 1'b1;
        wr_bank_next       = ~wr_bank;
        wr_row_next        = '0;
      end else begin
        wr_row_next = wr_row + RW'(1);
      end
    end
    if (rd_fire) begin
      if (rd_col == LAST) begin
        full_next[rd_bank] = 1'b0;
        rd_bank_next       = ~rd_bank;
        rd_col_next        = '0;
        blk_done_next      = 1'b1;
      end else begin
        rd_col_next = rd_col + RW'(1);
      end
    end
  end

  always_comb begin
    in_ready = !full[wr_bank] && !rst;
    out_valid = full[rd_bank];
    out_last = out_valid && (rd_col == LAST);
    wr_fire = bus.in_valid && in_ready;
    rd_fire = out_valid && bus.out_ready;
    wr_en = 2'b00;
    mode_en = 2'b00;
    wr_en[wr_bank] = wr_fire;
    mode_en[wr_bank] = wr_fire && (wr_row == '0);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tp_bank #(
      .N(N), .W(W), .APPROX_LO(APPROX_LO), .APPROX_HI(APPROX_HI)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[b]),
      .wr_row  (wr_row),
      .wr_data (bus.in_row),
      .mode_en (mode_en[b]),
      .mode_in (approx_mode_t'(bus.in_approx)),
      .rd_col  (rd_col),
      .rd_data (bank_col[b])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_col   = bank_col[rd_bank];
  assign bus.blk_done  = blk_done_q;

endmodule

// File: tb/tb_dct_transpose_pingpong.sv
// Bench for the ping-pong transpose: a block-level queue model predicts every
// column, handshake flag and done pulse; directed phases pin literal values.
module tb_dct_transpose_pingpong;

  localparam int N  = 8;
  localparam int W  = 12;
  localparam int LO = 2;
  localparam int HI = 4;

  typedef logic [N-1:0][W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dct_transpose_pingpong_if #(.N(N), .W(W)) bus ();

  dct_transpose_pingpong #(
    .N(N), .W(W), .APPROX_LO(LO), .APPROX_HI(HI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: columns of completed blocks still to be emitted, plus the block being filled.
  vec_t       exp_cols[$];
  vec_t       cur_rows[N];
  int         cur_cnt = 0;
  logic [1:0] cur_mode = 2'b00;
  int         rd_idx = 0;
  bit         done_pending = 1'b0;
  int         acc_rows = 0;
  bit         count_en = 1'b0;
  int         valid_cycles = 0, done_pulses = 0, first_v = -1, last_v = -1, cyc = 0;
  bit         rand_done = 1'b0;

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_vec(input string name, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_elem(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Truncation as floor to a multiple of 2^k, done with integer arithmetic.
  function automatic logic [W-1:0] model_approx(input logic [W-1:0] raw, input logic [1:0] m);
    int v, step, rem;
    v    = int'($signed(raw));
    step = (m == 2'b00) ? 1 : (m == 2'b01) ? (1 << LO) : (1 << HI);
    rem  = v % step;
    if (rem < 0) rem += step;
    return W'(v - rem);
  endfunction

  always @(negedge clk) begin
    bit   exp_ready, exp_valid, wr, rd;
    vec_t c;
    cyc++;
    if (rst) begin
      check_bit("reset_in_ready", bus.in_ready, 1'b0);
      check_bit("reset_out_valid", bus.out_valid, 1'b0);
      check_bit("reset_blk_done", bus.blk_done, 1'b0);
      exp_cols.delete();
      cur_cnt      = 0;
      rd_idx       = 0;
      done_pending = 1'b0;
    end else begin
      exp_ready = ((exp_cols.size() + N - 1) / N) < 2;
      exp_valid = exp_cols.size() > 0;
      check_bit("in_ready", bus.in_ready, exp_ready);
      check_bit("out_valid", bus.out_valid, exp_valid);
      check_bit("blk_done", bus.blk_done, done_pending);
      check_bit("out_last", bus.out_last, exp_valid && (rd_idx == N - 1));
      if (exp_valid) check_vec("out_col", bus.out_col, exp_cols[0]);
      if (count_en) begin
        if (bus.out_valid) begin
          valid_cycles++;
          if (first_v < 0) first_v = cyc;
          last_v = cyc;
        end
        if (bus.blk_done) done_pulses++;
      end
      wr = bus.in_valid && exp_ready;
      rd = exp_valid && bus.out_ready;
      done_pending = rd && (rd_idx == N - 1);
      if (rd) begin
        void'(exp_cols.pop_front());
        rd_idx = (rd_idx + 1) % N;
      end
      if (wr) begin
        acc_rows++;
        if (cur_cnt == 0) cur_mode = bus.in_approx;
        cur_rows[cur_cnt] = bus.in_row;
        cur_cnt++;
        if (cur_cnt == N) begin
          for (int j = 0; j < N; j++) begin
            for (int r = 0; r < N; r++) c[r] = model_approx(cur_rows[r][j], cur_mode);
            exp_cols.push_back(c);
          end
          cur_cnt = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_row(input vec_t row, input logic [1:0] mode);
    int guard;
    bit ok;
    bus.in_row    = row;
    bus.in_approx = mode;
    bus.in_valid  = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      guard++;
      if (guard > 2000) begin
        checks++;
        failures++;
        $display("[TB] FAIL send_timeout: row not accepted within 2000 cycles");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  function automatic vec_t rand_row();
    vec_t v;
    for (int c = 0; c < N; c++) v[c] = W'($urandom);
    return v;
  endfunction

  task automatic send_rand_block();
    logic [1:0] m;
    m = 2'($urandom_range(0, 3));
    for (int r = 0; r < N; r++) send_row(rand_row(), r == 0 ? m : 2'($urandom_range(0, 3)));
  endtask

  task automatic send_pattern_block();
    vec_t v;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) v[c] = W'(16 * r + c);
      send_row(v, 2'b00);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    bus.out_ready = 1'b1;
    while ((exp_cols.size() > 0 || done_pending) && g < 1000) begin
      tick(1);
      g++;
    end
    if (g >= 1000) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: %0d columns left", exp_cols.size());
    end
    tick(2);
  endtask

  initial begin
    vec_t v;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.in_approx = 2'b00;
    bus.out_ready = 1'b0;

    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check_bit("in_ready_after_reset", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Basic pattern block: latency, column contents, last flag and done pulse.
    bus.out_ready = 1'b1;
    send_pattern_block();
    @(negedge clk);
    check_bit("basic_latency_valid", bus.out_valid, 1'b1);
    check_elem("basic_col0_row5", bus.out_col[5], 12'd80);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check_elem("basic_col7_row2", bus.out_col[2], 12'd39);
    check_bit("basic_out_last", bus.out_last, 1'b1);
    @(negedge clk);
    check_bit("basic_blk_done", bus.blk_done, 1'b1);
    @(posedge clk); #1;
    drain();

    // Streaming: four back-to-back random blocks.
    first_v = -1; valid_cycles = 0; done_pulses = 0;
    count_en = 1'b1;
    for (int b = 0; b < 4; b++) send_rand_block();
    drain();
    count_en = 1'b0;
    check_int("stream_valid_cycles", valid_cycles, 4 * N);
    check_int("stream_blk_done", done_pulses, 4);
    check_int("stream_contiguous", last_v - first_v + 1, 4 * N);

    // Back-pressure: both banks fill, producer stalls, then everything drains in order.
    bus.out_ready = 1'b0;
    acc_rows = 0;
    fork
      begin
        for (int b = 0; b < 3; b++) send_rand_block();
      end
    join_none
    tick(40);
    check_int("bp_rows_accepted", acc_rows, 2 * N);
    check_bit("bp_in_ready_low", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    wait fork;
    drain();

    // Approx mode 01, with in_approx changing on later rows.
    v = rand_row();
    v[0] = 12'd7;
    v[1] = 12'hFFB;
    send_row(v, 2'b01);
    for (int r = 1; r < N; r++) send_row(rand_row(), 2'b11);
    @(negedge clk);
    check_elem("approx_lo_pos", bus.out_col[0], 12'h004);
    @(posedge clk);
    @(negedge clk);
    check_elem("approx_lo_neg", bus.out_col[0], 12'hFF8);
    @(posedge clk); #1;
    drain();

    // Approx mode 10 followed by mode 00 on the remaining rows.
    for (int r = 0; r < N; r++) begin
      v = rand_row();
      v[0] = 12'h07F;
      send_row(v, r == 0 ? 2'b10 : 2'b00);
    end
    @(negedge clk);
    check_elem("approx_hi_row0", bus.out_col[0], 12'h070);
    check_elem("approx_hi_row3", bus.out_col[3], 12'h070);
    @(posedge clk); #1;
    drain();

    // Reset after a partial block, then a fresh block.
    for (int r = 0; r < 5; r++) send_row(rand_row(), 2'b00);
    rst = 1'b1;
    @(negedge clk);
    check_bit("rst_mid_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_mid_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_pattern_block();
    @(negedge clk);
    check_elem("rst_fresh_col0_row1", bus.out_col[1], 12'd16);
    @(posedge clk); #1;
    drain();

    // One bank released on the same edge the other is completed.
    bus.out_ready = 1'b0;
    send_rand_block();
    for (int r = 0; r < N - 1; r++) send_row(rand_row(), 2'b00);
    bus.out_ready = 1'b1;
    tick(N - 1);
    send_row(rand_row(), 2'b00);
    @(negedge clk);
    check_bit("swap_in_ready", bus.in_ready, 1'b1);
    check_bit("swap_out_valid", bus.out_valid, 1'b1);
    check_bit("swap_blk_done", bus.blk_done, 1'b1);
    check_bit("swap_out_last", bus.out_last, 1'b0);
    @(posedge clk); #1;
    drain();

    // Random gaps on the input and random back-pressure on the output.
    rand_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          for (int r = 0; r < N; r++) begin
            tick($urandom_range(0, 2));
            send_row(rand_row(), 2'($urandom_range(0, 3)));
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
